// File: rtl/hazard_scoreboard_pkg.sv
// Shared constants and helpers for the hazard scoreboard and its register file.
package hazard_pkg;

   localparam int unsigned NUM_REGS_DEF = 32;
   localparam int unsigned MAX_PEND_DEF = 4;
   localparam int unsigned X0_IDX       = 0;

   typedef enum logic [1:0] {
      MD_NONE = 2'd0,
      MD_OK   = 2'd1,
      MD_ERR  = 2'd2
   } md_evt_e;

   // A completion is only legal when something is outstanding for that register.
   function automatic md_evt_e md_classify(input logic done,
                                           input logic pend_zero,
                                           input logic bit_busy);
      md_evt_e evt;
      evt = MD_NONE;
      if (done) begin
         if (pend_zero || !bit_busy) evt = MD_ERR;
         else                        evt = MD_OK;
      end
      return evt;
   endfunction

endpackage

// File: rtl/hazard_scoreboard_sb_regfile.sv
// Busy-bit register file with outstanding-operation counter and sticky protocol error.
module sb_regfile
   import hazard_pkg::*;
#(
   parameter int unsigned NUM_REGS = NUM_REGS_DEF,
   parameter int unsigned MAX_PEND = MAX_PEND_DEF,
   localparam int unsigned RW = $clog2(NUM_REGS),
   localparam int unsigned PW = $clog2(MAX_PEND + 1)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                set_en,
   input  logic [RW-1:0]       set_idx,
   input  logic                done_en,
   input  logic [RW-1:0]       done_idx,
   output logic                done_ok,
   output logic [NUM_REGS-1:0] busy_vec,
   output logic [PW-1:0]       md_pending,
   output logic                err
);

   logic [NUM_REGS-1:0] busy_q, busy_nxt;
   logic [PW-1:0]       pend_q, pend_nxt;
   logic                err_q, err_nxt;
   md_evt_e             evt;

   always_comb begin
      evt      = md_classify(done_en, pend_q == '0, busy_q[done_idx]);
      busy_nxt = busy_q;
      pend_nxt = pend_q;
      err_nxt  = err_q;
      if (evt == MD_ERR) err_nxt = 1'b1;
      if (evt == MD_OK) begin
         busy_nxt[done_idx] = 1'b0;
         pend_nxt           = pend_q - 1'b1;
      end
      // Set is applied after clear so a same-register issue/complete ends busy.
      if (set_en) begin
         busy_nxt[set_idx] = 1'b1;
         pend_nxt          = pend_nxt + 1'b1;
      end
      busy_nxt[X0_IDX] = 1'b0;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         busy_q <= '0;
         pend_q <= '0;
         err_q  <= 1'b0;
      end else begin
         busy_q <= busy_nxt;
         pend_q <= pend_nxt;
         err_q  <= err_nxt;
      end
   end

   assign done_ok    = (evt == MD_OK);
   assign busy_vec   = busy_q;
   assign md_pending = pend_q;
   assign err        = err_q;

endmodule

// File: rtl/hazard_scoreboard.sv
// ID-stage hazard detection: load-use, MULDIV RAW/WAW scoreboard and queue-full stalls.
module hazard_scoreboard
   import hazard_pkg::*;
#(
   parameter int unsigned NUM_REGS = NUM_REGS_DEF,
   parameter int unsigned MAX_PEND = MAX_PEND_DEF,
   parameter int unsigned CNT_W    = 32,
   localparam int unsigned RW = $clog2(NUM_REGS),
   localparam int unsigned PW = $clog2(MAX_PEND + 1)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                id_valid,
   input  logic [RW-1:0]       id_rs1,
   input  logic [RW-1:0]       id_rs2,
   input  logic                id_rs1_used,
   input  logic                id_rs2_used,
   input  logic [RW-1:0]       id_rd,
   input  logic                id_wr_en,
   input  logic                id_is_muldiv,
   input  logic                ex_memread,
   input  logic [RW-1:0]       ex_rd,
   input  logic                md_done,
   input  logic [RW-1:0]       md_rd,
   input  logic                flush,
   output logic                stall,
   output logic                pc_write,
   output logic                if_id_write,
   output logic                id_ex_flush,
   output logic [PW-1:0]       md_pending,
   output logic [NUM_REGS-1:0] busy_vec,
   output logic [CNT_W-1:0]    stall_cnt,
   output logic                err
);

   localparam logic [RW-1:0] X0 = RW'(X0_IDX);

   logic [NUM_REGS-1:0] done_mask, busy_eff;
   logic                load_use, raw_sb, waw_sb, md_full, issue, done_ok;

   always_comb begin
      done_mask = '0;
      if (md_done) done_mask[md_rd] = 1'b1;
      busy_eff = busy_vec & ~done_mask;
   end

   assign load_use = ex_memread && (ex_rd != X0) &&
                     ((id_rs1_used && (ex_rd == id_rs1)) ||
                      (id_rs2_used && (ex_rd == id_rs2)));
   assign raw_sb   = (id_rs1_used && busy_eff[id_rs1]) ||
                     (id_rs2_used && busy_eff[id_rs2]);
   assign waw_sb   = id_wr_en && (id_rd != X0) && busy_eff[id_rd];
   // A legal completion in the same cycle frees a slot for the waiting MULDIV.
   assign md_full  = id_is_muldiv && (md_pending == PW'(MAX_PEND)) && !done_ok;

   assign stall       = id_valid && (load_use || raw_sb || waw_sb || md_full);
   assign pc_write    = !stall;
   assign if_id_write = !stall;
   assign id_ex_flush = stall || flush;
   assign issue       = id_valid && !stall && !flush && id_is_muldiv && (id_rd != X0);

   sb_regfile #(
      .NUM_REGS (NUM_REGS),
      .MAX_PEND (MAX_PEND)
   ) u_sb (
      .clk        (clk),
      .rst        (rst),
      .set_en     (issue),
      .set_idx    (id_rd),
      .done_en    (md_done),
      .done_idx   (md_rd),
      .done_ok    (done_ok),
      .busy_vec   (busy_vec),
      .md_pending (md_pending),
      .err        (err)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                          stall_cnt <= '0;
      else if (stall && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
   end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed self-checking bench for hazard_scoreboard with hand-computed expectations.
module tb_hazard_scoreboard;

   logic        clk = 1'b0;
   logic        rst;
   logic        id_valid, id_rs1_used, id_rs2_used, id_wr_en, id_is_muldiv;
   logic [4:0]  id_rs1, id_rs2, id_rd, ex_rd, md_rd;
   logic        ex_memread, md_done, flush;
   logic        stall, pc_write, if_id_write, id_ex_flush, err;
   logic [2:0]  md_pending;
   logic [31:0] busy_vec;
   logic [31:0] stall_cnt;

   int unsigned n_tests = 0;
   int unsigned n_fail  = 0;

   hazard_scoreboard #(
      .NUM_REGS (32),
      .MAX_PEND (4),
      .CNT_W    (32)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .id_valid     (id_valid),
      .id_rs1       (id_rs1),
      .id_rs2       (id_rs2),
      .id_rs1_used  (id_rs1_used),
      .id_rs2_used  (id_rs2_used),
      .id_rd        (id_rd),
      .id_wr_en     (id_wr_en),
      .id_is_muldiv (id_is_muldiv),
      .ex_memread   (ex_memread),
      .ex_rd        (ex_rd),
      .md_done      (md_done),
      .md_rd        (md_rd),
      .flush        (flush),
      .stall        (stall),
      .pc_write     (pc_write),
      .if_id_write  (if_id_write),
      .id_ex_flush  (id_ex_flush),
      .md_pending   (md_pending),
      .busy_vec     (busy_vec),
      .stall_cnt    (stall_cnt),
      .err          (err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_rs1_used = 0; id_rs2_used = 0;
      id_rd = 0; id_wr_en = 0; id_is_muldiv = 0;
      ex_memread = 0; ex_rd = 0; md_done = 0; md_rd = 0; flush = 0;
   endtask

   task automatic mul(input logic [4:0] rd);
      idle();
      id_valid = 1; id_is_muldiv = 1; id_wr_en = 1; id_rd = rd;
   endtask

   task automatic done(input logic [4:0] rd);
      idle();
      md_done = 1; md_rd = rd;
   endtask

   initial begin
      idle();
      rst = 0;
      #12;
      chk("rst_busy", busy_vec, 0);
      chk("rst_pend", md_pending, 0);
      chk("rst_cnt", stall_cnt, 0);
      chk("rst_err", err, 0);
      chk("rst_stall", stall, 0);
      chk("rst_pcw", pc_write, 1);
      rst = 1;
      tick();

      // Load-use on rs2
      idle();
      id_valid = 1; ex_memread = 1; ex_rd = 5; id_rs2 = 5; id_rs2_used = 1;
      #1;
      chk("lu_stall", stall, 1);
      chk("lu_pcw", pc_write, 0);
      chk("lu_ifid", if_id_write, 0);
      chk("lu_flush", id_ex_flush, 1);
      tick();
      chk("lu_cnt", stall_cnt, 1);
      ex_memread = 0;
      #1;
      chk("lu_release", stall, 0);
      chk("lu_release_flush", id_ex_flush, 0);
      ex_memread = 1; ex_rd = 0; id_rs1 = 0; id_rs1_used = 1; id_rs2 = 0;
      #1;
      chk("lu_x0", stall, 0);

      // RAW on a MUL result, released by bypass
      mul(7);
      #1;
      chk("raw_issue_stall", stall, 0);
      tick();
      chk("raw_busy", busy_vec, 32'h0000_0080);
      chk("raw_pend", md_pending, 1);
      idle();
      id_valid = 1; id_rs1 = 7; id_rs1_used = 1; id_rd = 8; id_wr_en = 1;
      #1;
      chk("raw_stall1", stall, 1);
      tick();
      chk("raw_stall2", stall, 1);
      tick();
      chk("raw_cnt", stall_cnt, 3);
      md_done = 1; md_rd = 7;
      #1;
      chk("raw_bypass", stall, 0);
      tick();
      chk("raw_busy_clr", busy_vec, 0);
      chk("raw_pend_clr", md_pending, 0);
      chk("raw_cnt_hold", stall_cnt, 3);

      // Flush kills a MULDIV issue without stalling
      mul(10);
      flush = 1;
      #1;
      chk("fl_stall", stall, 0);
      chk("fl_idex", id_ex_flush, 1);
      tick();
      chk("fl_pend", md_pending, 0);
      chk("fl_busy", busy_vec, 0);

      // Fill the MULDIV queue
      for (int i = 1; i <= 4; i++) begin
         mul(5'(i));
         tick();
      end
      chk("full_pend", md_pending, 4);
      chk("full_busy", busy_vec, 32'h0000_001E);
      mul(5);
      #1;
      chk("full_stall", stall, 1);
      tick();
      chk("full_cnt", stall_cnt, 4);
      chk("full_pend_hold", md_pending, 4);
      md_done = 1; md_rd = 2;
      #1;
      chk("full_release", stall, 0);
      tick();
      chk("full_pend2", md_pending, 4);
      chk("full_busy2", busy_vec, 32'h0000_003A);

      // WAW, x0 destination exempt, bypass on destination
      idle();
      id_valid = 1; id_wr_en = 1; id_rd = 3;
      #1;
      chk("waw_stall", stall, 1);
      id_rd = 0;
      #1;
      chk("waw_x0", stall, 0);
      id_rd = 3; md_done = 1; md_rd = 3;
      #1;
      chk("waw_bypass", stall, 0);
      tick();
      chk("waw_busy", busy_vec, 32'h0000_0032);
      chk("waw_pend", md_pending, 3);

      // Simultaneous issue and completion of x9
      mul(9);
      tick();
      chk("sim_pre_busy", busy_vec, 32'h0000_0232);
      chk("sim_pre_pend", md_pending, 4);
      mul(9);
      md_done = 1; md_rd = 9;
      #1;
      chk("sim_stall", stall, 0);
      tick();
      chk("sim_busy", busy_vec, 32'h0000_0232);
      chk("sim_pend", md_pending, 4);

      // Drain and underflow error
      done(1); tick();
      done(4); tick();
      done(5); tick();
      done(9); tick();
      chk("drain_pend", md_pending, 0);
      chk("drain_busy", busy_vec, 0);
      chk("drain_err", err, 0);
      done(9); tick();
      chk("uf_err", err, 1);
      chk("uf_pend", md_pending, 0);
      idle(); tick();
      chk("uf_sticky", err, 1);

      // Reset mid-stall discards pending work
      mul(7); tick();
      idle();
      id_valid = 1; id_rs1 = 7; id_rs1_used = 1;
      #1;
      chk("rs_stall", stall, 1);
      tick();
      chk("rs_cnt_pre", stall_cnt, 5);
      rst = 0;
      #1;
      chk("rs_busy", busy_vec, 0);
      chk("rs_pend", md_pending, 0);
      chk("rs_cnt", stall_cnt, 0);
      chk("rs_err", err, 0);
      chk("rs_stall0", stall, 0);
      #2;
      rst = 1;
      done(7); tick();
      chk("rs_late_err", err, 1);
      chk("rs_late_pend", md_pending, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
